// File: rtl/tx_pkg.sv
// tx_pkg: shared types and constants for the serial frame transmitter
package tx_pkg;
    typedef enum logic [1:0] {IDLE, PREAMBLE, SYNC, PAYLOAD} state_t;
    localparam logic [15:0] SYNC_WORD_DEF = 16'h2DD4;
    localparam logic [6:0]  PRBS7_SEED    = 7'h7F;
    localparam logic [6:0]  PRBS7_TAPS    = 7'b110_0000;
endpackage

// File: rtl/lfsr7_scrambler.sv
// lfsr7_scrambler: PRBS7 (x^7+x^6+1) generator, output taken from the MSB
module lfsr7_scrambler import tx_pkg::*; (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic advance,
    output logic prbs_bit
);
    logic [6:0] r_lfsr;
    // reseed on load, otherwise shift one step per advance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_lfsr <= PRBS7_SEED;
        else if (load) r_lfsr <= PRBS7_SEED;
        else if (advance) r_lfsr <= {r_lfsr[5:0], ^(r_lfsr & PRBS7_TAPS)};
    end
    assign prbs_bit = r_lfsr[6];
endmodule

// File: rtl/tx_framer.sv
// tx_framer: serialises preamble, sync word and an optionally scrambled payload
module tx_framer import tx_pkg::*; #(
    parameter int          SYMBOL_DIV    = 16,
    parameter int          PREAMBLE_BITS = 16,
    parameter logic [15:0] SYNC_WORD     = SYNC_WORD_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] frame_len,
    input  logic       scram_en,
    input  logic [7:0] byte_in,
    input  logic       byte_valid,
    output logic       byte_ready,
    output logic       data_out,
    output logic       bit_strobe,
    output logic       busy,
    output logic       done,
    output logic       underrun
);
    localparam int CW = $clog2(SYMBOL_DIV);
    state_t      r_state, w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [15:0] r_bitcnt, w_bitcnt_nxt;
    logic [7:0]  r_len, r_sent, w_sent_nxt, r_acc, r_buf, r_sh, w_sh_nxt, w_nb;
    logic        r_scram, r_full, r_under, r_data, r_strobe;
    logic        w_wrap, w_prbs, w_mask, w_data_nxt, w_strobe_nxt;
    logic        w_load, w_adv, w_take, w_done, w_xfer;

    lfsr7_scrambler u_prbs (
        .clk      (clk),
        .rst      (rst),
        .load     (w_load),
        .advance  (w_adv),
        .prbs_bit (w_prbs)
    );

    assign w_wrap     = (r_state != IDLE) && (r_cnt == CW'(SYMBOL_DIV - 1));
    assign w_mask     = r_scram & w_prbs;
    assign w_nb       = r_full ? r_buf : 8'h00;
    assign byte_ready = (r_state == SYNC || r_state == PAYLOAD) && !r_full && (r_acc < r_len);
    assign w_xfer     = byte_valid && byte_ready;
    assign busy       = r_state != IDLE;
    assign done       = w_done;
    assign data_out   = r_data;
    assign bit_strobe = r_strobe;
    assign underrun   = r_under;

    // next state and next serial bit, decided at start and on every bit-timer wrap
    always_comb begin
        w_state_nxt  = r_state;
        w_bitcnt_nxt = r_bitcnt;
        w_sent_nxt   = r_sent;
        w_sh_nxt     = r_sh;
        w_data_nxt   = r_data;
        w_strobe_nxt = 1'b0;
        w_load       = 1'b0;
        w_adv        = 1'b0;
        w_take       = 1'b0;
        w_done       = 1'b0;
        if (r_state == IDLE) begin
            if (start) begin
                w_state_nxt  = PREAMBLE;
                w_bitcnt_nxt = '0;
                w_sent_nxt   = '0;
                w_data_nxt   = 1'b1;
                w_strobe_nxt = 1'b1;
                w_load       = 1'b1;
            end
        end else if (w_wrap) begin
            w_strobe_nxt = 1'b1;
            case (r_state)
                PREAMBLE: begin
                    if (r_bitcnt == 16'(PREAMBLE_BITS - 1)) begin
                        w_state_nxt  = SYNC;
                        w_bitcnt_nxt = '0;
                        w_data_nxt   = SYNC_WORD[15];
                    end else begin
                        w_bitcnt_nxt = r_bitcnt + 16'd1;
                        w_data_nxt   = r_bitcnt[0];
                    end
                end
                SYNC: begin
                    if (r_bitcnt == 16'd15) begin
                        w_done      = r_len == 8'd0;
                        w_take      = r_len != 8'd0;
                        w_state_nxt = PAYLOAD;
                    end else begin
                        w_bitcnt_nxt = r_bitcnt + 16'd1;
                        w_data_nxt   = SYNC_WORD[4'd14 - r_bitcnt[3:0]];
                    end
                end
                PAYLOAD: begin
                    if (r_bitcnt[2:0] == 3'd7) begin
                        w_sent_nxt = r_sent + 8'd1;
                        w_done     = (r_sent + 8'd1) == r_len;
                        w_take     = (r_sent + 8'd1) != r_len;
                    end else begin
                        w_bitcnt_nxt = r_bitcnt + 16'd1;
                        w_data_nxt   = r_sh[7] ^ w_mask;
                        w_sh_nxt     = {r_sh[6:0], 1'b0};
                        w_adv        = 1'b1;
                    end
                end
                default: ;
            endcase
            if (w_take) begin
                w_bitcnt_nxt = '0;
                w_data_nxt   = w_nb[7] ^ w_mask;
                w_sh_nxt     = {w_nb[6:0], 1'b0};
                w_adv        = 1'b1;
            end
            if (w_done) begin
                w_state_nxt  = IDLE;
                w_data_nxt   = 1'b0;
                w_strobe_nxt = 1'b0;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else r_state <= w_state_nxt;
    end

    // bit timer, serial output, holding buffer and frame bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_bitcnt <= '0;
            r_sent   <= '0;
            r_sh     <= '0;
            r_data   <= 1'b0;
            r_strobe <= 1'b0;
            r_len    <= '0;
            r_scram  <= 1'b0;
            r_acc    <= '0;
            r_buf    <= '0;
            r_full   <= 1'b0;
            r_under  <= 1'b0;
        end else begin
            r_cnt    <= (r_state == IDLE || w_wrap) ? '0 : r_cnt + 1'b1;
            r_bitcnt <= w_bitcnt_nxt;
            r_sent   <= w_sent_nxt;
            r_sh     <= w_sh_nxt;
            r_data   <= w_data_nxt;
            r_strobe <= w_strobe_nxt;
            if (w_load) begin
                r_len   <= frame_len;
                r_scram <= scram_en;
                r_acc   <= '0;
                r_full  <= 1'b0;
                r_under <= 1'b0;
            end else begin
                if (w_xfer) begin
                    r_buf  <= byte_in;
                    r_full <= 1'b1;
                    r_acc  <= r_acc + 8'd1;
                end else if (w_take) begin
                    r_full <= 1'b0;
                end
                if (w_take && !r_full) r_under <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_tx_framer.sv
// tb_tx_framer: table vectors, directed corner cases and random frames against a bit-stream model
module tb_tx_framer;
    localparam int DIV = 4;

    typedef struct {
        int          len;
        bit          scr;
        logic [7:0]  b0;
        logic [7:0]  b1;
        int          avail;
        logic [15:0] exp_pay;
        bit          exp_under;
        int          exp_nbits;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] frame_len = '0;
    logic       scram_en = 1'b0;
    logic [7:0] byte_in = '0;
    logic       byte_valid = 1'b0;
    logic       byte_ready, data_out, bit_strobe, busy, done, underrun;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] pay [0:15];
    bit         exp_q[$];
    bit         got[$];
    logic [15:0] sw = 16'h2DD4;
    vec_t       tbl [5];

    always #5 clk = ~clk;

    tx_framer #(.SYMBOL_DIV(DIV), .PREAMBLE_BITS(16), .SYNC_WORD(16'h2DD4)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .frame_len  (frame_len),
        .scram_en   (scram_en),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .data_out   (data_out),
        .bit_strobe (bit_strobe),
        .busy       (busy),
        .done       (done),
        .underrun   (underrun)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // expected serial stream: alternating preamble, sync MSB first, payload XOR PRBS7 sequence
    function automatic void build_expected(input int len, input bit scr, input int avail);
        bit p[$];
        exp_q.delete();
        for (int i = 0; i < 16; i++) exp_q.push_back(i % 2 == 0);
        for (int i = 15; i >= 0; i--) exp_q.push_back(sw[i]);
        for (int i = 0; i < 8 * len; i++) p.push_back(i < 7 ? 1'b1 : p[i-7] ^ p[i-6]);
        for (int b = 0; b < len; b++)
            for (int k = 7; k >= 0; k--)
                exp_q.push_back(((b < avail) ? pay[b][k] : 1'b0) ^ (scr & p[8*b + 7 - k]));
    endfunction

    task automatic run_frame(input int len, input bit scr, input int avail, input int inj, input string tag);
        int  idx = 0, busy_cnt = 0, done_cnt = 0, done_cyc = 0, hold_err = 0, rdy_err = 0, run = 0;
        int  nbits = 32 + 8 * len;
        int  limit = nbits * DIV + 40;
        bit  last = 1'b0, xfer;
        build_expected(len, scr, avail);
        got.delete();
        start = 1'b1;
        frame_len = 8'(len);
        scram_en = scr;
        @(posedge clk); #1;
        start = 1'b0;
        frame_len = 8'($urandom);
        scram_en = 1'($urandom);
        byte_valid = avail > 0;
        byte_in = pay[0];
        for (int cyc = 1; cyc <= limit; cyc++) begin
            if (cyc == 1) chk({tag, " underrun cleared by start"}, underrun, 0);
            if (busy) busy_cnt++;
            if (bit_strobe) begin
                if (cyc > 1 && run != DIV) hold_err++;
                got.push_back(data_out);
                last = data_out;
                run = 1;
            end else begin
                if (busy && data_out !== last) hold_err++;
                run++;
            end
            if (len == 0 && byte_ready) rdy_err++;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            start = (cyc == inj);
            if (cyc == inj) begin
                frame_len = 8'(len + 3);
                scram_en = ~scr;
            end
            xfer = byte_valid && byte_ready;
            if (done) break;
            @(posedge clk); #1;
            if (xfer) idx++;
            byte_valid = idx < avail;
            byte_in = (idx < avail) ? pay[idx] : 8'($urandom);
        end
        start = 1'b0;
        @(posedge clk); #1;
        byte_valid = 1'b0;
        chk({tag, " done count"}, done_cnt, 1);
        chk({tag, " done cycle"}, done_cyc, nbits * DIV);
        chk({tag, " busy cycles"}, busy_cnt, nbits * DIV);
        chk({tag, " bit count"}, got.size(), nbits);
        chk({tag, " bit hold errors"}, hold_err, 0);
        chk({tag, " byte_ready with len 0"}, rdy_err, 0);
        chk({tag, " underrun"}, underrun, (avail < len) ? 1 : 0);
        chk({tag, " idle busy"}, busy, 0);
        chk({tag, " idle data_out"}, data_out, 0);
        for (int i = 0; i < exp_q.size(); i++)
            chk($sformatf("%s bit %0d", tag, i), (i < got.size()) ? 32'(got[i]) : 32'd2, 32'(exp_q[i]));
    endtask

    initial begin
        tbl[0] = '{len: 1, scr: 0, b0: 8'hA5, b1: 8'h00, avail: 1, exp_pay: 16'hA500, exp_under: 0, exp_nbits: 40};
        tbl[1] = '{len: 1, scr: 1, b0: 8'h00, b1: 8'h00, avail: 1, exp_pay: 16'hFE00, exp_under: 0, exp_nbits: 40};
        tbl[2] = '{len: 2, scr: 0, b0: 8'hA5, b1: 8'h3C, avail: 1, exp_pay: 16'hA500, exp_under: 1, exp_nbits: 48};
        tbl[3] = '{len: 0, scr: 0, b0: 8'h00, b1: 8'h00, avail: 0, exp_pay: 16'h0000, exp_under: 0, exp_nbits: 32};
        tbl[4] = '{len: 2, scr: 1, b0: 8'hFF, b1: 8'hFF, avail: 2, exp_pay: 16'h01FB, exp_under: 0, exp_nbits: 48};

        repeat (3) @(posedge clk);
        #1;
        chk("reset data_out", data_out, 0);
        chk("reset bit_strobe", bit_strobe, 0);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset byte_ready", byte_ready, 0);
        chk("reset underrun", underrun, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int t = 0; t < 5; t++) begin
            pay[0] = tbl[t].b0;
            pay[1] = tbl[t].b1;
            run_frame(tbl[t].len, tbl[t].scr, tbl[t].avail, -1, $sformatf("vec%0d", t));
            chk($sformatf("vec%0d table nbits", t), got.size(), tbl[t].exp_nbits);
            chk($sformatf("vec%0d table underrun", t), underrun, tbl[t].exp_under);
            for (int k = 0; k < 8 * tbl[t].len; k++)
                chk($sformatf("vec%0d table payload bit %0d", t, k),
                    (32 + k < got.size()) ? 32'(got[32 + k]) : 32'd2, 32'(tbl[t].exp_pay[15 - k]));
        end

        // start pulsed mid-payload must not alter length or scrambling
        for (int i = 0; i < 3; i++) pay[i] = 8'($urandom);
        run_frame(3, 1, 3, 36 * DIV, "midstart");

        // reset in the middle of the sync word aborts the frame without done
        begin
            int dn = 0;
            pay[0] = 8'h5A;
            start = 1'b1;
            frame_len = 8'd2;
            scram_en = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            for (int c = 0; c < 20 * DIV; c++) begin
                if (done) dn++;
                @(posedge clk); #1;
            end
            chk("abort busy before reset", busy, 1);
            #1 rst = 1'b1;
            #1;
            chk("abort data_out", data_out, 0);
            chk("abort bit_strobe", bit_strobe, 0);
            chk("abort busy", busy, 0);
            chk("abort done", done, 0);
            chk("abort byte_ready", byte_ready, 0);
            chk("abort underrun", underrun, 0);
            for (int c = 0; c < 4; c++) begin
                @(posedge clk); #1;
                if (done) dn++;
            end
            chk("abort no done pulse", dn, 0);
            rst = 1'b0;
            @(posedge clk); #1;
            pay[0] = 8'hC3;
            run_frame(1, 0, 1, -1, "after_abort");
        end

        // random frames, some with withheld trailing bytes
        for (int r = 0; r < 20; r++) begin
            int len = $urandom_range(0, 5);
            int avail = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len) : len;
            for (int i = 0; i < 16; i++) pay[i] = 8'($urandom);
            run_frame(len, 1'($urandom), avail, -1, $sformatf("rnd%0d", r));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
